// File: rtl/sik_decode.sv
// sik_decode: two-thread stack-machine instruction decoder with registered output slot
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   in_valid/in_tid/in_inst/in_ready   fetch side, valid/ready handshake
//   out_valid/out_ready   decode side handshake
//   out_tid, out_ext, out_op           thread, stack-ALU class flag, opcode
//   out_src1/src2/dst     register-file indices {tid, stack slot}, 0 when unused
//   out_wen, out_imm      destination write enable, resolved immediate
//   halt                  both threads have executed sys
//
// Optional feature macro: SIK_PRE_EN enables the 1111 prefix that supplies imm[15:12].
//
// Opcode map. Major [15:12]: 0 ext, 1 push, 2 get, 3 put, 4 pop, 5 call, 6 jump,
// 7 jumpf, 8 jumpt, 9 sys, F pre, others undefined.
// Extended [3:0]: 1 add, 2 lt, 3 sub, 4 and, 5 or, 6 xor, 7 dup, 8 ret, 9 test,
// A load, B store, others undefined.
module sik_decode #(
  parameter int NTHREAD = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_tid,
  input  logic [15:0] in_inst,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_tid,
  output logic        out_ext,
  output logic [3:0]  out_op,
  output logic [8:0]  out_src1,
  output logic [8:0]  out_src2,
  output logic [8:0]  out_dst,
  output logic        out_wen,
  output logic [15:0] out_imm,
  output logic        halt
);
  // Extended ops live in the upper half of the 5-bit code space so one case covers both.
  localparam logic [4:0] C_PUSH  = 5'h01, C_GET   = 5'h02, C_PUT   = 5'h03, C_POP  = 5'h04,
                         C_CALL  = 5'h05, C_JUMP  = 5'h06, C_JUMPF = 5'h07, C_JUMPT = 5'h08,
                         C_SYS   = 5'h09, C_PRE   = 5'h0F,
                         C_ADD   = 5'h11, C_LT    = 5'h12, C_SUB   = 5'h13, C_AND  = 5'h14,
                         C_OR    = 5'h15, C_XOR   = 5'h16, C_DUP   = 5'h17, C_RET  = 5'h18,
                         C_TEST  = 5'h19, C_LOAD  = 5'h1A, C_STORE = 5'h1B;
  logic [7:0]         sp [NTHREAD];
  logic [NTHREAD-1:0] halted;
`ifdef SIK_PRE_EN
  logic [3:0]         pre [NTHREAD];
  logic [NTHREAD-1:0] pre_v;
`endif
  logic        ext, wen, is_pre, is_sys, accept, emit;
  logic [3:0]  major;
  logic [4:0]  code;
  logic [15:0] imm;
  logic [7:0]  s, p1, m1, mk, sp_n;
  logic [8:0]  src1, src2, dst;
  assign in_ready = !out_valid || out_ready;
  assign halt     = &halted;
  assign accept   = in_valid && in_ready && !halted[in_tid];
  assign emit     = accept && !is_pre;
  always_comb begin
    major = in_inst[15:12];
    ext   = major == 4'h0;
    code  = ext ? {1'b1, in_inst[3:0]} : {1'b0, major};
`ifdef SIK_PRE_EN
    imm   = pre_v[in_tid] ? {pre[in_tid], in_inst[11:0]} : {{4{in_inst[11]}}, in_inst[11:0]};
`else
    imm   = {{4{in_inst[11]}}, in_inst[11:0]};
`endif
    s      = sp[in_tid];
    p1     = s + 8'd1;
    m1     = s - 8'd1;
    mk     = s - imm[7:0];
    src1   = '0;
    src2   = '0;
    dst    = '0;
    wen    = 1'b0;
    sp_n   = s;
    is_pre = 1'b0;
    is_sys = 1'b0;
    case (code)
      C_PUSH, C_CALL: begin dst = {in_tid, p1}; wen = 1'b1; sp_n = p1; end
      C_GET:          begin src1 = {in_tid, mk}; dst = {in_tid, p1}; wen = 1'b1; sp_n = p1; end
      C_PUT:          begin src1 = {in_tid, s}; dst = {in_tid, mk}; wen = 1'b1; end
      C_POP:          sp_n = mk;
      C_JUMP:         ;
      C_JUMPF, C_JUMPT, C_RET: begin src1 = {in_tid, s}; sp_n = m1; end
      C_SYS:          is_sys = 1'b1;
`ifdef SIK_PRE_EN
      C_PRE:          is_pre = 1'b1;
`endif
      C_ADD, C_LT, C_SUB, C_AND, C_OR, C_XOR: begin
        src1 = {in_tid, m1};
        src2 = {in_tid, s};
        dst  = {in_tid, m1};
        wen  = 1'b1;
        sp_n = m1;
      end
      C_DUP:          begin src1 = {in_tid, s}; dst = {in_tid, p1}; wen = 1'b1; sp_n = p1; end
      C_TEST, C_LOAD: begin src1 = {in_tid, s}; dst = {in_tid, s}; wen = 1'b1; end
      C_STORE:        begin src1 = {in_tid, m1}; src2 = {in_tid, s}; sp_n = s - 8'd2; end
      default:        ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NTHREAD; i++) sp[i] <= 8'hFF;
      halted    <= '0;
`ifdef SIK_PRE_EN
      for (int i = 0; i < NTHREAD; i++) pre[i] <= 4'h0;
      pre_v     <= '0;
`endif
      out_valid <= 1'b0;
      out_tid   <= 1'b0;
      out_ext   <= 1'b0;
      out_op    <= 4'h0;
      out_src1  <= '0;
      out_src2  <= '0;
      out_dst   <= '0;
      out_wen   <= 1'b0;
      out_imm   <= '0;
    end else if (in_ready) begin
      out_valid <= emit;
      if (emit) begin
        out_tid  <= in_tid;
        out_ext  <= ext;
        out_op   <= ext ? in_inst[3:0] : major;
        out_src1 <= src1;
        out_src2 <= src2;
        out_dst  <= dst;
        out_wen  <= wen;
        out_imm  <= imm;
      end
      if (accept) begin
        sp[in_tid]     <= sp_n;
        halted[in_tid] <= halted[in_tid] | is_sys;
`ifdef SIK_PRE_EN
        pre_v[in_tid]  <= is_pre;
        if (is_pre) pre[in_tid] <= in_inst[3:0];
`endif
      end
    end
  end
endmodule

// File: tb/tb_sik_decode.sv
// tb_sik_decode: directed-vector self-checking bench for sik_decode
module tb_sik_decode;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_tid = 1'b0;
  logic [15:0] in_inst = '0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_tid;
  logic        out_ext;
  logic [3:0]  out_op;
  logic [8:0]  out_src1, out_src2, out_dst;
  logic        out_wen;
  logic [15:0] out_imm;
  logic        halt;
  int n_cmp = 0;
  int n_err = 0;
  sik_decode dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_tid(in_tid), .in_inst(in_inst),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .out_tid(out_tid),
    .out_ext(out_ext), .out_op(out_op), .out_src1(out_src1), .out_src2(out_src2),
    .out_dst(out_dst), .out_wen(out_wen), .out_imm(out_imm), .halt(halt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic t, input logic [15:0] i);
    in_valid = 1'b1;
    in_tid   = t;
    in_inst  = i;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_valid", out_valid, 0);
    check("rst_halt", halt, 0);
    check("rst_dst", out_dst, 0);
    check("rst_imm", out_imm, 0);
    check("rst_ready", in_ready, 1);
    // push 5 on tid0 from sp=FF
    issue(0, 16'h1005);
    check("push_valid", out_valid, 1);
    check("push_dst", out_dst, 9'h000);
    check("push_imm", out_imm, 16'h0005);
    check("push_wen", out_wen, 1);
    check("push_ext", out_ext, 0);
    check("push_op", out_op, 4'h1);
    issue(0, 16'h1000);
    check("push2_dst", out_dst, 9'h001);
    // tid0 sp=01: add
    issue(0, 16'h0001);
    check("add_src1", out_src1, 9'h000);
    check("add_src2", out_src2, 9'h001);
    check("add_dst", out_dst, 9'h000);
    check("add_ext", out_ext, 1);
    check("add_op", out_op, 4'h1);
    check("add_wen", out_wen, 1);
    issue(0, 16'h1000);
    check("post_add_dst", out_dst, 9'h001);
    // tid1 prefix then pushes
    issue(1, 16'hF00A);
`ifdef SIK_PRE_EN
    check("pre_bubble", out_valid, 0);
`else
    check("pre_undef_valid", out_valid, 1);
    check("pre_undef_wen", out_wen, 0);
    check("pre_undef_dst", out_dst, 0);
`endif
    issue(1, 16'h1123);
    check("pre_push_valid", out_valid, 1);
`ifdef SIK_PRE_EN
    check("pre_push_imm", out_imm, 16'hA123);
`else
    check("pre_push_imm", out_imm, 16'h0123);
`endif
    check("pre_push_dst", out_dst, 9'h100);
    check("pre_push_tid", out_tid, 1);
    issue(1, 16'h1800);
    check("sext_imm", out_imm, 16'hF800);
    check("sext_dst", out_dst, 9'h101);
    // wrap checks from reset
    do_reset();
    issue(0, 16'h4001);
    check("pop_valid", out_valid, 1);
    check("pop_wen", out_wen, 0);
    check("pop_dst", out_dst, 0);
    issue(0, 16'h1000);
    check("wrap_dst", out_dst, 9'h0FF);
    // sp=FF: get 2
    issue(0, 16'h2002);
    check("get_src1", out_src1, 9'h0FD);
    check("get_dst", out_dst, 9'h000);
    // sp=00: put 1
    issue(0, 16'h3001);
    check("put_src1", out_src1, 9'h000);
    check("put_dst", out_dst, 9'h0FF);
    // sp=00: store
    issue(0, 16'h000B);
    check("store_src1", out_src1, 9'h0FF);
    check("store_src2", out_src2, 9'h000);
    check("store_wen", out_wen, 0);
    // sp=FE: dup
    issue(0, 16'h0007);
    check("dup_src1", out_src1, 9'h0FE);
    check("dup_dst", out_dst, 9'h0FF);
    // sp=FF: undefined major
    issue(0, 16'hA000);
    check("undef_valid", out_valid, 1);
    check("undef_wen", out_wen, 0);
    check("undef_src1", out_src1, 0);
    issue(0, 16'h1000);
    check("undef_sp", out_dst, 9'h000);
    // stall with a pending push
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_tid    = 1'b0;
    in_inst   = 16'h1000;
    #1;
    check("stall_ready", in_ready, 0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check("stall_ready_hold", in_ready, 0);
      check("stall_valid", out_valid, 1);
      check("stall_dst", out_dst, 9'h000);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("release_dst", out_dst, 9'h001);
    // halting
    issue(0, 16'h9000);
    check("sys0_valid", out_valid, 1);
    check("sys0_wen", out_wen, 0);
    check("sys0_halt", halt, 0);
    issue(0, 16'h1000);
    check("drop_valid", out_valid, 0);
    check("drop_ready", in_ready, 1);
    check("drop_halt", halt, 0);
    issue(1, 16'h9000);
    check("sys1_valid", out_valid, 1);
    check("halt_set", halt, 1);
    // reset in the middle of a stall
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = 16'h1000;
    @(posedge clk);
    #1;
    check("stall2_ready", in_ready, 0);
    check("halt_sticky", halt, 1);
    do_reset();
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("rst2_valid", out_valid, 0);
    check("rst2_halt", halt, 0);
    check("rst2_dst", out_dst, 0);
    issue(0, 16'h1000);
    check("rst2_push_dst", out_dst, 9'h000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
